// File: rtl/tea_block_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tea_block_packer                                                           |
// | Packs a ciphertext byte stream into held 64-bit blocks for the TEA decoder.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tea_block_packer #(
  parameter bit         BYTE_ORDER_LE = 1'b1,
  parameter logic [7:0] PAD_BYTE      = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [63:0] outBlock64,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_nbytes,
  output logic        out_last
);

  localparam logic [63:0] C_PAD_BLOCK = {8{PAD_BYTE}};

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [63:0] r_block;
  logic        r_out_valid;
  logic [3:0]  r_nbytes;
  logic        r_last;

  logic        w_byte_xfer;

  // HOLD accepts a byte only in the cycle its block is taken, keeping 1 byte/cycle.
  assign in_ready    = rst & ((r_state == FILL) | out_ready);
  assign w_byte_xfer = in_valid & in_ready;

  assign outBlock64  = r_block;
  assign out_valid   = r_out_valid;
  assign out_nbytes  = r_nbytes;
  assign out_last    = r_last;

  function automatic logic [63:0] put_byte(input logic [63:0] blk,
                                           input logic [2:0]  lane,
                                           input logic [7:0]  b);
    logic [63:0] r;
    logic [5:0]  base;
    r    = blk;
    base = BYTE_ORDER_LE ? {lane, 3'b000} : (6'd56 - {lane, 3'b000});
    r[base +: 8] = b;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= FILL;
      r_cnt       <= 3'd0;
      r_block     <= C_PAD_BLOCK;
      r_out_valid <= 1'b0;
      r_nbytes    <= 4'd0;
      r_last      <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_byte_xfer) begin
            r_block <= put_byte(r_block, r_cnt, in_data);
            if ((r_cnt == 3'd7) || in_last) begin
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
              r_nbytes    <= {1'b0, r_cnt} + 4'd1;
              r_last      <= in_last;
              r_cnt       <= 3'd0;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (w_byte_xfer) begin
              r_block <= put_byte(C_PAD_BLOCK, 3'd0, in_data);
              if (in_last) begin
                // One-byte final message: straight back to a held block.
                r_state     <= HOLD;
                r_out_valid <= 1'b1;
                r_nbytes    <= 4'd1;
                r_last      <= 1'b1;
                r_cnt       <= 3'd0;
              end else begin
                r_state     <= FILL;
                r_out_valid <= 1'b0;
                r_nbytes    <= 4'd0;
                r_last      <= 1'b0;
                r_cnt       <= 3'd1;
              end
            end else begin
              r_block     <= C_PAD_BLOCK;
              r_state     <= FILL;
              r_out_valid <= 1'b0;
              r_nbytes    <= 4'd0;
              r_last      <= 1'b0;
              r_cnt       <= 3'd0;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/tea_block_packer.md
Name: tea_block_packer

Overview:
- Upstream feeder for the combinational TEA decryptor.
- Accepts a ciphertext byte stream over a valid/ready handshake and packs it into registered 64-bit blocks.
- Presents each block on outBlock64 with a valid/ready handshake, so the decryptor input is held stable while the consumer stalls.
- A partial final block is padded; its byte count and last flag are reported alongside it.

Parameters:
- BYTE_ORDER_LE, 1: 1 = first byte of a block goes to [7:0]; 0 = first byte goes to [63:56].
- PAD_BYTE, 8'h00: value written into unfilled byte lanes of a short final block.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-low.
- in_data  input  8  ciphertext byte.
- in_valid  input  1  in_data is valid.
- in_last  input  1  in_data is the final byte of the message; qualified by in_valid.
- in_ready  output  1  packer can accept a byte this cycle.
- outBlock64  output  64  packed block; [31:0] = V0, [63:32] = V1 to the decryptor.
- out_valid  output  1  outBlock64 holds a complete or final block.
- out_ready  input  1  consumer takes the block this cycle.
- out_nbytes  output  4  number of real bytes in the block, 1..8.
- out_last  output  1  block ends the message.

Behaviour:
- State register: FILL or HOLD. Byte counter cnt: 3 bits, 0..7.
- Byte transfer: in_valid & in_ready. Block transfer: out_valid & out_ready.
- Reset (rst = 0 at a clock edge):
  - state = FILL, cnt = 0.
  - Block register = {8{PAD_BYTE}}.
  - out_valid = 0, out_nbytes = 0, out_last = 0.
  - in_ready is forced to 0 combinationally while rst = 0.
  - Reset asserted mid-FILL or mid-HOLD discards the partial or pending block; no output.
- in_ready = rst & (state == FILL | (state == HOLD & out_ready)). This is the only combinational input-to-output path.
- FILL, byte transfer:
  - Write in_data into lane cnt. Lane k = bits [8k+7:8k] when BYTE_ORDER_LE = 1; bits [63-8k:56-8k] when 0.
  - If cnt == 7 or in_last: go to HOLD next cycle.
    - out_valid = 1, out_nbytes = cnt + 1, out_last = in_last, cnt = 0.
  - Otherwise cnt = cnt + 1.
- Latency: the byte that completes a block is accepted at edge N; out_valid = 1 from edge N (visible in cycle N+1). No further delay.
- HOLD, out_ready = 0:
  - outBlock64, out_nbytes and out_last are held bit-stable.
  - in_ready = 0; in_data is ignored.
- HOLD, out_ready = 1 (block transfer):
  - Block register is reloaded to {8{PAD_BYTE}}.
  - If a byte transfer occurs in the same cycle, that byte lands in lane 0 of the new block and cnt = 1. Exception: if it has in_last set, the new block goes straight to HOLD with out_nbytes = 1 and out_last = 1 (out_valid stays 1).
  - With no byte transfer: state = FILL, out_valid = 0, out_nbytes = 0, out_last = 0.
- Sustained throughput: 1 byte per cycle, including across block boundaries, while out_ready stays 1.
- Short final block: lanes cnt+1..7 hold PAD_BYTE. out_nbytes is the true count.
- in_last on the 8th byte gives out_nbytes = 8 and out_last = 1.
- Empty messages (last with no byte) cannot be expressed and are not supported.
- Bytes presented while in_ready = 0 are neither consumed nor corrupted. The upstream must hold them.

Test Plan:
- Full LE block: BYTE_ORDER_LE = 1, bytes 01,02,…,08 on consecutive cycles, out_ready = 1 → outBlock64 = 64'h0807060504030201, out_nbytes = 8, out_last = 0, out_valid high for exactly 1 cycle, starting the cycle after byte 08 is accepted.
- Big-endian order: BYTE_ORDER_LE = 0, same bytes → outBlock64 = 64'h0102030405060708.
- Short final block: bytes AA,BB,CC with in_last on CC, PAD_BYTE = 00 → outBlock64 = 64'h0000000000CCBBAA, out_nbytes = 3, out_last = 1.
  - Repeat with PAD_BYTE = 8'h5A → upper five lanes = 5A.
- Backpressure: full block, then out_ready = 0 for 5 cycles with in_valid held at 1 and in_data = 99 → in_ready = 0 throughout, outputs bit-stable, 99 not consumed. When out_ready rises, 99 becomes lane 0 of the next block.
- Back-to-back: 16 bytes 00..0F with continuous in_valid and out_ready = 1 → in_ready never drops, blocks 64'h0706050403020100 and 64'h0F0E0D0C0B0A0908 appear in successive 8-cycle windows.
- Reset mid-operation:
  - 5 bytes accepted, then rst = 0 for 1 cycle → out_valid stays 0, in_ready = 0 during reset. Next 8 bytes 11..18 yield exactly 64'h1817161514131211.
  - Reset asserted during HOLD → out_valid = 0 on the following cycle.
